sm_fixed_addacc: RTL and testbench

Parametrised, pipelined, saturating adder/accumulator for sign-magnitude fixed-point words (1 sign bit, WIDTH-1 magnitude bits; Q1.15 at the default). It generalises the combinational 16-bit saturating adder:
- configurable width;
- a valid/ready stream interface with backpressure;
- a running-accumulate mode;
- saturation event reporting.

It sits between datapath producers and consumers wherever fixed-point sums or running sums are needed.

---
 rtl/sm_fixed_addacc.sv | 139 +++++++++++++
 tb/tb_sm_fixed_addacc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_fixed_addacc.sv
// Pipelined saturating sign-magnitude adder/accumulator with valid/ready handshake.
// Two stages: S1 captures the beat, S2 computes the sum, updates acc and registers the result.
module sm_fixed_addacc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_sat,
    output logic [WIDTH-1:0] acc_value,
    output logic [CNT_W-1:0] sat_count
);

    localparam int MW = WIDTH - 1;

    typedef struct packed {
        logic             sat;
        logic [WIDTH-1:0] word;
    } sumT;

    logic             r_s1Valid;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;
    logic             r_s1Mode;
    logic             r_s1Clr;

    logic             r_outValid;
    logic [WIDTH-1:0] r_outResult;
    logic             r_outSat;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_satCount;

    logic             w_stall;
    logic [WIDTH-1:0] w_opP;
    logic [WIDTH-1:0] w_opQ;
    sumT              w_sum;

    // Negative zero on either operand collapses to +0, and a zero-magnitude result is always +0.
    function automatic sumT smAdd(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
        logic [MW-1:0] magP;
        logic [MW-1:0] magQ;
        logic          signP;
        logic          signQ;
        logic [MW:0]   wide;
        logic [MW-1:0] mag;
        logic          sign;
        logic          sat;
        sumT           res;
        magP  = p[MW-1:0];
        magQ  = q[MW-1:0];
        signP = p[WIDTH-1] & (|magP);
        signQ = q[WIDTH-1] & (|magQ);
        wide  = {1'b0, magP} + {1'b0, magQ};
        sat   = 1'b0;
        if (signP == signQ) begin
            sign = signP;
            if (wide[MW]) begin
                mag = '1;
                sat = 1'b1;
            end else begin
                mag = wide[MW-1:0];
            end
        end else if (magP >= magQ) begin
            mag  = magP - magQ;
            sign = signP;
        end else begin
            mag  = magQ - magP;
            sign = signQ;
        end
        res.sat  = sat;
        res.word = {sign & (|mag), mag};
        return res;
    endfunction

    assign w_stall  = r_outValid && !out_ready;
    // Ready is forced high while reset is asserted, even if the output was stalled.
    assign in_ready = !w_stall || !RST;

    always_comb begin
        w_opP = r_s1A;
        w_opQ = r_s1B;
        if (r_s1Mode) begin
            w_opP = r_s1Clr ? '0 : r_acc;
            w_opQ = r_s1A;
        end
        w_sum = smAdd(w_opP, w_opQ);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_s1Valid   <= 1'b0;
            r_s1A       <= '0;
            r_s1B       <= '0;
            r_s1Mode    <= 1'b0;
            r_s1Clr     <= 1'b0;
            r_outValid  <= 1'b0;
            r_outResult <= '0;
            r_outSat    <= 1'b0;
            r_acc       <= '0;
            r_satCount  <= '0;
        end else if (!w_stall) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1A    <= in_a;
                r_s1B    <= in_b;
                r_s1Mode <= in_mode;
                r_s1Clr  <= in_clr;
            end
            r_outValid <= r_s1Valid;
            // A bubble in S1 leaves the result, acc and counter untouched.
            if (r_s1Valid) begin
                r_outResult <= w_sum.word;
                r_outSat    <= w_sum.sat;
                if (r_s1Mode) begin
                    r_acc <= w_sum.word;
                end
                if (w_sum.sat && (r_satCount != '1)) begin
                    r_satCount <= r_satCount + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid  = r_outValid;
    assign out_result = r_outResult;
    assign out_sat    = r_outSat;
    assign acc_value  = r_acc;
    assign sat_count  = r_satCount;

endmodule

// File: tb/tb_sm_fixed_addacc.sv
// Directed, table-driven bench for sm_fixed_addacc with hand-computed expectations.
// A second instance with CNT_W=2 exercises the saturation counter ceiling.
module tb_sm_fixed_addacc;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        mode;
        logic        clr;
        logic [15:0] expRes;
        logic        expSat;
        logic [15:0] expAcc;
        logic [7:0]  expCnt;
    } vecT;

    logic        CLK;
    logic        RST;
    logic        inValid;
    logic        inReady;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        inMode;
    logic        inClr;
    logic        outValid;
    logic        outReady;
    logic [15:0] outResult;
    logic        outSat;
    logic [15:0] accValue;
    logic [7:0]  satCount;

    logic        inValid2;
    logic        inReady2;
    logic        outValid2;
    logic [15:0] outResult2;
    logic        outSat2;
    logic [15:0] accValue2;
    logic [1:0]  satCount2;

    int total;
    int bad;
    vecT vecs[$];

    sm_fixed_addacc #(.WIDTH(16), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(inValid), .in_ready(inReady),
        .in_a(inA), .in_b(inB), .in_mode(inMode), .in_clr(inClr),
        .out_valid(outValid), .out_ready(outReady),
        .out_result(outResult), .out_sat(outSat),
        .acc_value(accValue), .sat_count(satCount)
    );

    sm_fixed_addacc #(.WIDTH(16), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST),
        .in_valid(inValid2), .in_ready(inReady2),
        .in_a(16'h4000), .in_b(16'h4000), .in_mode(1'b0), .in_clr(1'b0),
        .out_valid(outValid2), .out_ready(1'b1),
        .out_result(outResult2), .out_sat(outSat2),
        .acc_value(accValue2), .sat_count(satCount2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic mode, input logic clr);
        inValid = v;
        inA     = a;
        inB     = b;
        inMode  = mode;
        inClr   = clr;
    endtask

    function automatic vecT mk(input logic [15:0] a, input logic [15:0] b, input logic mode,
                               input logic clr, input logic [15:0] r, input logic s,
                               input logic [15:0] acc, input logic [7:0] cnt);
        vecT v;
        v.a = a; v.b = b; v.mode = mode; v.clr = clr;
        v.expRes = r; v.expSat = s; v.expAcc = acc; v.expCnt = cnt;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        // ADD saturation/sign cases; 2aaa+5555 lands exactly on max, so it does not saturate.
        vecs.push_back(mk(16'h4000, 16'h4000, 0, 0, 16'h7fff, 1, 16'h0000, 8'd1));
        vecs.push_back(mk(16'hc000, 16'hc000, 0, 0, 16'hffff, 1, 16'h0000, 8'd2));
        vecs.push_back(mk(16'hc000, 16'h2000, 0, 0, 16'ha000, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'ha000, 16'h4000, 0, 0, 16'h2000, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'h2aaa, 16'h5555, 0, 0, 16'h7fff, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'h8000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'h4000, 16'hc000, 0, 0, 16'h0000, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'h8001, 16'h0001, 0, 0, 16'h0000, 0, 16'h0000, 8'd2));
        vecs.push_back(mk(16'h0001, 16'h8003, 0, 0, 16'h8002, 0, 16'h0000, 8'd2));
        // ACC run with operand B set to junk to prove it is ignored.
        vecs.push_back(mk(16'h4000, 16'h7fff, 1, 1, 16'h4000, 0, 16'h4000, 8'd2));
        vecs.push_back(mk(16'h3000, 16'h7fff, 1, 0, 16'h7000, 0, 16'h7000, 8'd2));
        vecs.push_back(mk(16'h2000, 16'h0000, 1, 0, 16'h7fff, 1, 16'h7fff, 8'd3));
        vecs.push_back(mk(16'hc000, 16'h1234, 1, 0, 16'h3fff, 0, 16'h3fff, 8'd3));
        vecs.push_back(mk(16'h1000, 16'h1000, 0, 0, 16'h2000, 0, 16'h3fff, 8'd3));

        RST      = 1'b0;
        outReady = 1'b1;
        inValid2 = 1'b0;
        applyStimulus(0, 16'h0, 16'h0, 0, 0);
        tick();
        tick();
        checkOutput("reset in_ready", inReady, 1);
        RST = 1'b1;
        tick();
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset out_result", outResult, 0);
        checkOutput("reset out_sat", outSat, 0);
        checkOutput("reset acc_value", accValue, 0);
        checkOutput("reset sat_count", satCount, 0);
        checkOutput("idle in_ready", inReady, 1);

        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size())
                applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].clr);
            else
                applyStimulus(0, 16'h0, 16'h0, 0, 0);
            tick();
            if (i >= 1) begin
                checkOutput($sformatf("vec%0d out_valid", i - 1), outValid, 1);
                checkOutput($sformatf("vec%0d out_result", i - 1), outResult, vecs[i-1].expRes);
                checkOutput($sformatf("vec%0d out_sat", i - 1), outSat, vecs[i-1].expSat);
                checkOutput($sformatf("vec%0d acc_value", i - 1), accValue, vecs[i-1].expAcc);
                checkOutput($sformatf("vec%0d sat_count", i - 1), satCount, vecs[i-1].expCnt);
            end
        end
        tick();
        checkOutput("drain out_valid", outValid, 0);

        // Backpressure: three beats offered while the consumer is blocked.
        outReady = 1'b0;
        applyStimulus(1, 16'h0100, 16'h0200, 0, 0);
        tick();
        checkOutput("bp in_ready before out_valid", inReady, 1);
        applyStimulus(1, 16'h0001, 16'h0002, 0, 0);
        tick();
        checkOutput("bp out_valid", outValid, 1);
        checkOutput("bp in_ready drop", inReady, 0);
        applyStimulus(1, 16'h0005, 16'h0005, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp held result", outResult, 16'h0300);
            checkOutput("bp held valid", outValid, 1);
            checkOutput("bp held in_ready", inReady, 0);
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp release in_ready", inReady, 1);
        tick();
        applyStimulus(0, 16'h0, 16'h0, 0, 0);
        checkOutput("bp second result", outResult, 16'h0003);
        checkOutput("bp second valid", outValid, 1);
        tick();
        checkOutput("bp third result", outResult, 16'h000a);
        checkOutput("bp third valid", outValid, 1);
        tick();
        checkOutput("bp no duplicate", outValid, 0);
        checkOutput("bp acc untouched", accValue, 16'h3fff);

        // Reset with two beats in flight and a fresh beat offered in the reset cycle.
        applyStimulus(1, 16'h0010, 16'h0010, 0, 0);
        tick();
        applyStimulus(1, 16'h0020, 16'h0020, 1, 0);
        tick();
        checkOutput("pre-reset out_valid", outValid, 1);
        applyStimulus(1, 16'h0030, 16'h0030, 1, 0);
        RST      = 1'b0;
        outReady = 1'b0;
        #1;
        checkOutput("in_ready during reset", inReady, 1);
        tick();
        RST      = 1'b1;
        outReady = 1'b1;
        applyStimulus(0, 16'h0, 16'h0, 0, 0);
        checkOutput("post-reset out_valid", outValid, 0);
        checkOutput("post-reset acc_value", accValue, 0);
        checkOutput("post-reset sat_count", satCount, 0);
        checkOutput("post-reset in_ready", inReady, 1);
        tick();
        checkOutput("flushed beat stays gone", outValid, 0);
        applyStimulus(1, 16'h0001, 16'h0001, 0, 0);
        tick();
        applyStimulus(0, 16'h0, 16'h0, 0, 0);
        checkOutput("post-reset latency1", outValid, 0);
        tick();
        checkOutput("post-reset latency2 valid", outValid, 1);
        checkOutput("post-reset result", outResult, 16'h0002);
        checkOutput("post-reset acc stays 0", accValue, 0);

        // Counter ceiling on the narrow-counter instance.
        for (int i = 0; i <= 5; i++) begin
            inValid2 = (i < 5);
            tick();
            if (i >= 1) begin
                checkOutput($sformatf("cnt2 sat beat%0d", i - 1), outSat2, 1);
                checkOutput($sformatf("cnt2 count beat%0d", i - 1), satCount2, (i < 3) ? i : 3);
            end
        end
        tick();
        tick();
        checkOutput("cnt2 holds at ceiling", satCount2, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
